rv32_regfile_mp: RTL and testbench

//   Multi-port integer register file for the rv32 pipeline.
//   - Parametrised in data width, architectural register count, read ports and write ports.
//   - Sits between decode (addresses) and execute (operand values).
//   - Read data is registered (1-cycle latency) and held while the pipeline stalls.
//   - Register x0 is hardwired to zero.
//   - Optional same-cycle write-to-read bypass.
//

---
 rtl/rv32_regfile_mp.sv | 64 ++++++
 tb/tb_rv32_regfile_mp.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rv32_regfile_mp.sv
// rv32_regfile_mp: multi-port register file, registered reads, x0 = 0, optional bypass via RV32_REGFILE_BYPASS_EN
module rv32_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_in,
    input  logic [NUM_RD*5-1:0]    rs_in,
    input  logic [NUM_WR*5-1:0]    rd_in,
    input  logic [NUM_WR-1:0]      rd_writeback_in,
    input  logic [NUM_WR*XLEN-1:0] rd_value_in,
    output logic [NUM_RD*XLEN-1:0] rs_value_out
);
`ifdef RV32_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [5:0] NR = 6'(NUM_REGS);
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] wd [NUM_REGS];
    logic [NUM_REGS-1:0] we;
    logic [NUM_RD*XLEN-1:0] rv;
    logic [4:0] ra;
    logic rhit;
    // x0 never matches, so regs[0] stays at its reset value of zero; later ports override earlier ones
    always_comb begin
        we = '0;
        for (int r = 0; r < NUM_REGS; r++) wd[r] = '0;
        for (int r = 1; r < NUM_REGS; r++)
            for (int w = 0; w < NUM_WR; w++)
                if (rd_writeback_in[w] && rd_in[5*w +: 5] == 5'(r)) begin
                    we[r] = 1'b1;
                    wd[r] = rd_value_in[XLEN*w +: XLEN];
                end
    end
    always_comb begin
        rv   = '0;
        ra   = '0;
        rhit = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra   = rs_in[5*p +: 5];
            rhit = ra != 5'd0 && {1'b0, ra} < NR;
            rv[XLEN*p +: XLEN] = rhit ? regs[ra[AW-1:0]] : '0;
            for (int w = 0; w < NUM_WR; w++)
                if (BYPASS && rhit && rd_writeback_in[w] && rd_in[5*w +: 5] == ra)
                    rv[XLEN*p +: XLEN] = rd_value_in[XLEN*w +: XLEN];
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            rs_value_out <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (we[r]) regs[r] <= wd[r];
            if (!stall_in) rs_value_out <= rv;
        end
    end
endmodule

// File: tb/tb_rv32_regfile_mp.sv
// tb_rv32_regfile_mp: directed vector bench for rv32_regfile_mp (2R/2W/32 regs plus a 1R/1W/16 reg instance)
module tb_rv32_regfile_mp;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stall_a = 1'b0, stall_b = 1'b0;
    logic [9:0] rs_a = '0, rd_a = '0;
    logic [1:0] we_a = '0;
    logic [63:0] wv_a = '0, out_a;
    logic [4:0] rs_b = '0, rd_b = '0;
    logic [0:0] we_b = '0;
    logic [31:0] wv_b = '0, out_b;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    rv32_regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dut_a (
        .clk(clk), .reset(reset), .stall_in(stall_a), .rs_in(rs_a), .rd_in(rd_a),
        .rd_writeback_in(we_a), .rd_value_in(wv_a), .rs_value_out(out_a)
    );
    rv32_regfile_mp #(.XLEN(32), .NUM_REGS(16), .NUM_RD(1), .NUM_WR(1)) dut_b (
        .clk(clk), .reset(reset), .stall_in(stall_b), .rs_in(rs_b), .rd_in(rd_b),
        .rd_writeback_in(we_b), .rd_value_in(wv_b), .rs_value_out(out_b)
    );
    typedef struct {
        logic stall;
        logic [4:0] rs0, rs1;
        logic [1:0] we;
        logic [4:0] rd0, rd1;
        logic [31:0] wv0, wv1, e0, e1;
    } vec_t;
    vec_t tbl [13];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive_a(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] we,
                           input logic [4:0] d0, input logic [4:0] d1,
                           input logic [31:0] v0, input logic [31:0] v1);
        rs_a = {r1, r0};
        we_a = we;
        rd_a = {d1, d0};
        wv_a = {v1, v0};
    endtask
    logic [31:0] exp_byp;
    initial begin
        tbl[0]  = '{1'b0, 5'd1,  5'd2,  2'b01, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b0, 5'd5,  5'd5,  2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd5,  5'd31, 2'b01, 5'd0,  5'd0, 32'hFFFFFFFF, 32'h0,        32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b0, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
        tbl[4]  = '{1'b0, 5'd5,  5'd0,  2'b11, 5'd9,  5'd9, 32'h1,        32'h2,        32'hDEADBEEF, 32'h0};
        tbl[5]  = '{1'b0, 5'd9,  5'd9,  2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        32'h2,        32'h2};
        tbl[6]  = '{1'b0, 5'd9,  5'd5,  2'b11, 5'd31, 5'd1, 32'hCAFEF00D, 32'h12345678, 32'h2,        32'hDEADBEEF};
        tbl[7]  = '{1'b0, 5'd31, 5'd1,  2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        32'hCAFEF00D, 32'h12345678};
        tbl[8]  = '{1'b0, 5'd31, 5'd9,  2'b10, 5'd31, 5'd1, 32'h0000FFFF, 32'hAAAA0000, 32'hCAFEF00D, 32'h2};
        tbl[9]  = '{1'b0, 5'd31, 5'd1,  2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        32'hCAFEF00D, 32'hAAAA0000};
        tbl[10] = '{1'b0, 5'd9,  5'd9,  2'b01, 5'd3,  5'd0, 32'h55,       32'h0,        32'h2,        32'h2};
        tbl[11] = '{1'b0, 5'd3,  5'd0,  2'b01, 5'd7,  5'd0, 32'h11,       32'h0,        32'h55,       32'h0};
        tbl[12] = '{1'b0, 5'd7,  5'd3,  2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        32'h11,       32'h55};
        #1 reset = 1'b1;
        #1;
        chk("reset_out_a", out_a[31:0], 32'h0);
        chk("reset_out_b", out_b, 32'h0);
        step();
        step();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            drive_a(5'(a), 5'(31 - a), 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
            step();
            chk($sformatf("init_rd0_x%0d", a), out_a[31:0], 32'h0);
            chk($sformatf("init_rd1_x%0d", 31 - a), out_a[63:32], 32'h0);
        end
        for (int i = 0; i < 13; i++) begin
            stall_a = tbl[i].stall;
            drive_a(tbl[i].rs0, tbl[i].rs1, tbl[i].we, tbl[i].rd0, tbl[i].rd1, tbl[i].wv0, tbl[i].wv1);
            step();
            chk($sformatf("vec%0d_p0", i), out_a[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_p1", i), out_a[63:32], tbl[i].e1);
        end
`ifdef RV32_REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'h00000011;
`endif
        drive_a(5'd7, 5'd3, 2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0);
        step();
        chk("bypass_same_cycle", out_a[31:0], exp_byp);
        chk("bypass_other_port", out_a[63:32], 32'h55);
        drive_a(5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("bypass_next_p0", out_a[31:0], 32'hA5A5A5A5);
        chk("bypass_next_p1", out_a[63:32], 32'hA5A5A5A5);
        drive_a(5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("pre_stall", out_a[31:0], 32'h55);
        stall_a = 1'b1;
        drive_a(5'd7, 5'd9, 2'b01, 5'd3, 5'd0, 32'h77, 32'h0);
        step();
        chk("stall_c1", out_a[31:0], 32'h55);
        drive_a(5'd9, 5'd1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("stall_c2", out_a[31:0], 32'h55);
        drive_a(5'd5, 5'd31, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("stall_c3", out_a[31:0], 32'h55);
        chk("stall_c3_p1", out_a[63:32], 32'h0);
        stall_a = 1'b0;
        drive_a(5'd3, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("unstall_p0", out_a[31:0], 32'h77);
        chk("unstall_p1", out_a[63:32], 32'hDEADBEEF);
        stall_a = 1'b1;
        drive_a(5'd7, 5'd0, 2'b01, 5'd4, 5'd0, 32'h99, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_p0", out_a[31:0], 32'h0);
        chk("async_reset_p1", out_a[63:32], 32'h0);
        step();
        we_a = 2'b00;
        reset = 1'b0;
        stall_a = 1'b0;
        drive_a(5'd4, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("reset_drops_write", out_a[31:0], 32'h0);
        chk("reset_clears_x3", out_a[63:32], 32'h0);
        rd_b = 5'd20;
        wv_b = 32'h1234;
        we_b = 1'b1;
        rs_b = 5'd0;
        step();
        rd_b = 5'd15;
        wv_b = 32'hBEEF;
        rs_b = 5'd20;
        step();
        chk("rv32e_x20_read", out_b, 32'h0);
        we_b = 1'b0;
        rs_b = 5'd4;
        step();
        chk("rv32e_no_alias_x4", out_b, 32'h0);
        rs_b = 5'd15;
        step();
        chk("rv32e_x15", out_b, 32'hBEEF);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
